// File: rtl/fifo_sync_param_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : fifo_sync_param_pkg                                                |
// | Purpose: Shared defaults and operation encoding for the synchronous FIFO.   |
// |          BYTE_W / FIFO_ADDR_W are the bridge-wide default word width and    |
// |          address width; fifo_op_e names the accepted-access combinations.  |
// | Rev    : 1.0  initial release                                               |
// +----------------------------------------------------------------------------+
package fifo_sync_param_pkg;

  localparam int BYTE_W      = 8;
  localparam int FIFO_ADDR_W = 4;

  // Encoding is {write accepted, read accepted}
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_RW   = 2'b11
  } fifo_op_e;

endpackage
`default_nettype wire

// File: rtl/fifo_dp_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : fifo_dp_ram                                                        |
// | Purpose: Simple dual-port RAM, DATA_W x 2**ADDR_W, synchronous write,       |
// |          asynchronous read. With REG_OUT=1 the read word is captured into   |
// |          an output register on re_i (cleared by rst); with REG_OUT=0 the    |
// |          addressed word is presented combinationally.                      |
// | Ports  : clk, rst            clock / sync active-high reset                 |
// |          we_i, waddr_i, wdata_i  write port                                 |
// |          re_i, raddr_i        read strobe (REG_OUT=1 only) and address      |
// |          rdata_o              read word                                     |
// | Rev    : 1.0  initial release                                               |
// +----------------------------------------------------------------------------+
module fifo_dp_ram #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int REG_OUT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 1 << ADDR_W;

  // Storage is intentionally not reset so it can map onto RAM primitives
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  generate
    if (REG_OUT != 0) begin : g_reg_out
      logic [DATA_W-1:0] rdata_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          rdata_q <= '0;
        end else if (re_i) begin
          rdata_q <= mem_q[raddr_i];
        end
      end
      assign rdata_o = rdata_q;
    end else begin : g_comb_out
      // Reset and read strobe have no role when the output is combinational
      logic unused_ok;
      assign unused_ok = ^{rst, re_i};
      assign rdata_o   = mem_q[raddr_i];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/fifo_sync_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : fifo_sync_param                                                    |
// | Purpose: Parametrised single-clock FIFO using all 2**ADDR_W entries, with   |
// |          occupancy count, almost-full/almost-empty thresholds,              |
// |          overflow/underflow pulses and optional first-word-fall-through.   |
// | Ports  : clk, rst            clock / sync active-high reset                 |
// |          wr_en, wr_data      write request and word                         |
// |          rd_en               read request (FWFT=1: pop head)                |
// |          rd_data, rd_valid   read word and its qualifier                    |
// |          full, empty, almost_full, almost_empty, count   status             |
// |          overflow, underflow 1-cycle pulses for rejected requests           |
// | Rev    : 1.0  initial release                                               |
// +----------------------------------------------------------------------------+
module fifo_sync_param
  import fifo_sync_param_pkg::*;
#(
  parameter int DATA_W        = BYTE_W,
  parameter int ADDR_W        = FIFO_ADDR_W,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 2,
  parameter int FWFT          = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] C_DEPTH  = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] C_AFULL  = AFULL_THRESH[ADDR_W:0];
  localparam logic [ADDR_W:0] C_AEMPTY = AEMPTY_THRESH[ADDR_W:0];
  localparam logic [ADDR_W:0] C_ONE    = {{ADDR_W{1'b0}}, 1'b1};

  generate
    if (!(AEMPTY_THRESH > 0 && AEMPTY_THRESH < AFULL_THRESH && AFULL_THRESH <= DEPTH))
    begin : g_bad_thresh
      $error("fifo_sync_param: need 0 < AEMPTY_THRESH < AFULL_THRESH <= DEPTH");
    end
  endgenerate

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  logic [ADDR_W:0] wptr_q, rptr_q;
  logic [ADDR_W:0] count_q, count_d;
  logic            full_q, empty_q, afull_q, aempty_q;
  logic            ovf_q, udf_q;
  logic            wr_acc, rd_acc;
  fifo_op_e        op;

  // Acceptance uses this cycle's registered flags, so a full FIFO can still
  // pop while rejecting the write, and an empty one can still push.
  assign wr_acc = wr_en & ~full_q;
  assign rd_acc = rd_en & ~empty_q;
  assign op     = fifo_op_e'({wr_acc, rd_acc});

  always_comb begin
    count_d = count_q;
    case (op)
      OP_WR:   count_d = count_q + C_ONE;
      OP_RD:   count_d = count_q - C_ONE;
      default: count_d = count_q;
    endcase
  end

  // All status flags derive from count_d so they agree with count each cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      if (wr_acc) begin
        wptr_q <= wptr_q + C_ONE;
      end
      if (rd_acc) begin
        rptr_q <= rptr_q + C_ONE;
      end
      count_q  <= count_d;
      full_q   <= (count_d == C_DEPTH);
      empty_q  <= (count_d == '0);
      afull_q  <= (count_d >= C_AFULL);
      aempty_q <= (count_d <= C_AEMPTY);
      ovf_q    <= wr_en & full_q;
      udf_q    <= rd_en & empty_q;
    end
  end

  fifo_dp_ram #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .REG_OUT ((FWFT == 0) ? 1 : 0)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wr_acc),
    .waddr_i (wptr_q[ADDR_W-1:0]),
    .wdata_i (wr_data),
    .re_i    (rd_acc),
    .raddr_i (rptr_q[ADDR_W-1:0]),
    .rdata_o (rd_data)
  );

  generate
    if (FWFT == 0) begin : g_std_valid
      logic rd_valid_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_acc;
        end
      end
      assign rd_valid = rd_valid_q;
    end else begin : g_fwft_valid
      // Head word is presented combinationally whenever anything is stored
      assign rd_valid = ~empty_q;
    end
  endgenerate

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_fifo_sync_param                                                 |
// | Purpose: Self-checking bench for fifo_sync_param. A registered-read         |
// |          instance is checked against a queue-based reference model, a      |
// |          constant vector table and directed corner sequences; a second     |
// |          FWFT instance is checked with directed sequences.                  |
// | Rev    : 1.0  initial release                                               |
// +----------------------------------------------------------------------------+
module tb_fifo_sync_param;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read instance
  logic       rst = 1'b1;
  logic       wr_en = 1'b0, rd_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] rd_data;
  logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  fifo_sync_param #(.DATA_W(8), .ADDR_W(4), .AFULL_THRESH(12), .AEMPTY_THRESH(2), .FWFT(0)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  // FWFT instance
  logic       f_rst = 1'b1;
  logic       f_wr = 1'b0, f_rd = 1'b0;
  logic [7:0] f_wdata = 8'h00;
  logic [7:0] f_rdata;
  logic       f_valid, f_full, f_empty, f_afull, f_aempty, f_ovf, f_udf;
  logic [4:0] f_count;

  fifo_sync_param #(.DATA_W(8), .ADDR_W(4), .AFULL_THRESH(12), .AEMPTY_THRESH(2), .FWFT(1)) dut_fwft (
    .clk(clk), .rst(f_rst), .wr_en(f_wr), .wr_data(f_wdata), .rd_en(f_rd),
    .rd_data(f_rdata), .rd_valid(f_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_afull), .almost_empty(f_aempty), .count(f_count),
    .overflow(f_ovf), .underflow(f_udf)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: a plain queue plus the observable output registers
  int         m_q[$];
  logic [7:0] m_rd    = 8'h00;
  bit         m_valid = 1'b0;
  bit         m_ovf   = 1'b0;
  bit         m_udf   = 1'b0;

  task automatic model_reset();
    m_q.delete();
    m_rd = 8'h00; m_valid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
  endtask

  task automatic model_step(input bit wr, input bit rd, input logic [7:0] d);
    bit was_full, was_empty;
    was_full  = (m_q.size() == 16);
    was_empty = (m_q.size() == 0);
    m_ovf = wr && was_full;
    m_udf = rd && was_empty;
    if (rd && !was_empty) begin
      m_rd    = 8'(m_q.pop_front());
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    if (wr && !was_full) m_q.push_back(int'(d));
  endtask

  task automatic check_model(input string tag);
    int n;
    n = m_q.size();
    chk({tag, "_count"},    int'(count),        n);
    chk({tag, "_full"},     int'(full),         int'(n == 16));
    chk({tag, "_empty"},    int'(empty),        int'(n == 0));
    chk({tag, "_afull"},    int'(almost_full),  int'(n >= 12));
    chk({tag, "_aempty"},   int'(almost_empty), int'(n <= 2));
    chk({tag, "_rd_valid"}, int'(rd_valid),     int'(m_valid));
    chk({tag, "_rd_data"},  int'(rd_data),      int'(m_rd));
    chk({tag, "_overflow"}, int'(overflow),     int'(m_ovf));
    chk({tag, "_underflow"},int'(underflow),    int'(m_udf));
  endtask

  task automatic cyc(input string tag, input bit wr, input bit rd, input logic [7:0] d);
    wr_en = wr; rd_en = rd; wr_data = d;
    @(posedge clk); #1;
    model_step(wr, rd, d);
    check_model(tag);
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    @(posedge clk); #1;
    model_reset();
    check_model(tag);
    rst = 1'b0;
  endtask

  typedef struct {
    bit         wr;
    bit         rd;
    logic [7:0] din;
    int         e_count;
    bit         e_empty;
    bit         e_udf;
    bit         e_valid;
    logic [7:0] e_rd;
  } vec_t;

  vec_t tbl[8];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    tbl[0] = '{1'b1, 1'b0, 8'h11, 1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[1] = '{1'b1, 1'b0, 8'h22, 2, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[2] = '{1'b1, 1'b1, 8'h33, 2, 1'b0, 1'b0, 1'b1, 8'h11};
    tbl[3] = '{1'b0, 1'b1, 8'h00, 1, 1'b0, 1'b0, 1'b1, 8'h22};
    tbl[4] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b1, 8'h33};
    tbl[5] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b1, 1'b0, 8'h33};
    tbl[6] = '{1'b1, 1'b1, 8'h44, 1, 1'b0, 1'b1, 1'b0, 8'h33};
    tbl[7] = '{1'b0, 1'b0, 8'h00, 1, 1'b0, 1'b0, 1'b0, 8'h33};

    @(posedge clk); #1;
    f_rst = 1'b0;

    // Reset state
    do_reset("reset");

    // Test 1: fill, almost_full threshold, overflow on 17th write
    for (int i = 0; i < 16; i++) begin
      cyc("t1_fill", 1'b1, 1'b0, 8'(i));
      if (i == 10) chk("t1_afull_at11", int'(almost_full), 0);
      if (i == 11) chk("t1_afull_at12", int'(almost_full), 1);
      if (i == 14) chk("t1_full_at15",  int'(full), 0);
    end
    chk("t1_full_at16", int'(full), 1);
    chk("t1_count16",   int'(count), 16);
    cyc("t1_ovf", 1'b1, 1'b0, 8'hAA);
    chk("t1_ovf_pulse",   int'(overflow), 1);
    chk("t1_ovf_count16", int'(count), 16);
    cyc("t1_after_ovf", 1'b0, 1'b0, 8'h00);
    chk("t1_ovf_one_cycle", int'(overflow), 0);

    // Test 2: drain in order, underflow on extra read
    for (int i = 0; i < 16; i++) begin
      cyc("t2_drain", 1'b0, 1'b1, 8'h00);
      chk("t2_order", int'(rd_data), i);
    end
    chk("t2_empty", int'(empty), 1);
    cyc("t2_udf", 1'b0, 1'b1, 8'h00);
    chk("t2_udf_pulse", int'(underflow), 1);
    chk("t2_udf_valid", int'(rd_valid), 0);

    // Constant vector table from a clean reset
    do_reset("tbl_reset");
    foreach (tbl[k]) begin
      cyc("tbl_model", tbl[k].wr, tbl[k].rd, tbl[k].din);
      chk("tbl_count", int'(count),     tbl[k].e_count);
      chk("tbl_empty", int'(empty),     int'(tbl[k].e_empty));
      chk("tbl_udf",   int'(underflow), int'(tbl[k].e_udf));
      chk("tbl_valid", int'(rd_valid),  int'(tbl[k].e_valid));
      chk("tbl_rdata", int'(rd_data),   int'(tbl[k].e_rd));
    end

    // Test 3: steady count 8 with simultaneous read/write across pointer wrap
    do_reset("t3_reset");
    for (int i = 0; i < 8; i++) cyc("t3_fill", 1'b1, 1'b0, 8'(8'h80 + i));
    for (int i = 0; i < 40; i++) begin
      cyc("t3_rw", 1'b1, 1'b1, 8'(8'h40 + i));
      chk("t3_count8", int'(count), 8);
    end

    // Test 4: full + both, then empty + both
    do_reset("t4_reset");
    for (int i = 0; i < 16; i++) cyc("t4_fill", 1'b1, 1'b0, 8'(i));
    cyc("t4_full_rw", 1'b1, 1'b1, 8'hBB);
    chk("t4_rd00",     int'(rd_data), 0);
    chk("t4_ovf",      int'(overflow), 1);
    chk("t4_count15",  int'(count), 15);
    for (int i = 0; i < 15; i++) cyc("t4_drain", 1'b0, 1'b1, 8'h00);
    cyc("t4_empty_rw", 1'b1, 1'b1, 8'hCC);
    chk("t4_udf",      int'(underflow), 1);
    chk("t4_count1",   int'(count), 1);
    cyc("t4_read_cc", 1'b0, 1'b1, 8'h00);
    chk("t4_rd_cc",    int'(rd_data), 8'hCC);

    // Test 6: reset mid-burst at count 9
    do_reset("t6_reset0");
    for (int i = 0; i < 9; i++) cyc("t6_fill", 1'b1, 1'b0, 8'(8'hD0 + i));
    chk("t6_count9", int'(count), 9);
    do_reset("t6_reset");
    chk("t6_count0",  int'(count), 0);
    chk("t6_empty",   int'(empty), 1);
    chk("t6_aempty",  int'(almost_empty), 1);
    chk("t6_valid0",  int'(rd_valid), 0);
    for (int i = 0; i < 3; i++) cyc("t6_wr", 1'b1, 1'b0, 8'(8'hE0 + i));
    for (int i = 0; i < 3; i++) begin
      cyc("t6_rd", 1'b0, 1'b1, 8'h00);
      chk("t6_order", int'(rd_data), 8'hE0 + i);
    end

    // Randomised traffic: write-heavy phase, then read-heavy phase
    do_reset("rnd_reset");
    for (int i = 0; i < 400; i++) begin
      int p;
      p = (i < 200) ? 70 : 30;
      cyc("rnd", ($urandom_range(0, 99) < p), ($urandom_range(0, 99) < (100 - p)),
          8'($urandom_range(0, 255)));
    end

    // Test 5: FWFT instance
    f_rst = 1'b1;
    @(posedge clk); #1;
    f_rst = 1'b0;
    chk("t5_rst_empty", int'(f_empty), 1);
    chk("t5_rst_valid", int'(f_valid), 0);
    f_wr = 1'b1; f_wdata = 8'h5A;
    @(posedge clk); #1;
    f_wr = 1'b0;
    chk("t5_valid",  int'(f_valid), 1);
    chk("t5_data5a", int'(f_rdata), 8'h5A);
    @(posedge clk); #1;
    chk("t5_hold_valid", int'(f_valid), 1);
    chk("t5_hold_data",  int'(f_rdata), 8'h5A);
    f_rd = 1'b1;
    @(posedge clk); #1;
    f_rd = 1'b0;
    chk("t5_pop_empty", int'(f_empty), 1);
    chk("t5_pop_valid", int'(f_valid), 0);
    f_wr = 1'b1; f_wdata = 8'hA1;
    @(posedge clk); #1;
    f_wdata = 8'hA2;
    @(posedge clk); #1;
    f_wr = 1'b0;
    chk("t5_head_a1", int'(f_rdata), 8'hA1);
    chk("t5_count2",  int'(f_count), 2);
    f_rd = 1'b1;
    @(posedge clk); #1;
    f_rd = 1'b0;
    chk("t5_head_a2", int'(f_rdata), 8'hA2);
    chk("t5_count1",  int'(f_count), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
